// File: rtl/arc_halt_run_responder_if.sv
// Signal bundle between the external ARC halt/run host and the core-side responder.
// The responder takes the slave view; the host/core side takes the master view.
interface arc_halt_run_responder_if;
    logic ext_arc_halt_req_a;
    logic ext_arc_halt_ack;
    logic ext_arc_run_ack;
    logic core_halt_req;
    logic core_run_req;
    logic core_halted;

    modport slave (
        input  ext_arc_halt_req_a,
        input  core_halted,
        output ext_arc_halt_ack,
        output ext_arc_run_ack,
        output core_halt_req,
        output core_run_req
    );

    modport master (
        output ext_arc_halt_req_a,
        output core_halted,
        input  ext_arc_halt_ack,
        input  ext_arc_run_ack,
        input  core_halt_req,
        input  core_run_req
    );
endinterface

// File: rtl/arc_halt_run_responder.sv
// Core-side responder for the external ARC 4-phase halt/run handshake: synchronizes the
// async halt request, sequences the core halt/run request lines and flags stalled handshakes.
module arc_halt_run_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 11
) (
    input  logic                      clk,
    input  logic                      rst_a,
    arc_halt_run_responder_if.slave   arc,
    input  logic                      err_clr,
    output logic                      timeout_err,
    output logic [1:0]                fsm_state
);

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        HALTING  = 2'd1,
        HALTED   = 2'd2,
        RESUMING = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(ACK_TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_SAT) ? CNT_SAT : v + CNT_W'(1);
    endfunction

    function automatic logic is_wait(input state_e s);
        return (s == HALTING) || (s == RESUMING);
    endfunction

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_s;
    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   err_set;
    logic                   halt_ack_q;
    logic                   run_ack_q;
    logic                   halt_req_q;
    logic                   run_req_q;
    logic                   timeout_err_q;

    // Stage: request synchronizer; nothing downstream looks at the raw input.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], arc.ext_arc_halt_req_a};
        end
    end

    assign req_s = req_sync_q[SYNC_STAGES-1];

    // Abort (request dropped) takes priority over the core reporting halted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUNNING: begin
                if (req_s) state_d = HALTING;
            end
            HALTING: begin
                if (!req_s)               state_d = RESUMING;
                else if (arc.core_halted) state_d = HALTED;
            end
            HALTED: begin
                if (!req_s) state_d = RESUMING;
            end
            RESUMING: begin
                if (!arc.core_halted) state_d = req_s ? HALTING : RUNNING;
            end
            default: state_d = RUNNING;
        endcase
    end

    // Counter restarts on every entry into a waiting state and is parked at 0 elsewhere.
    always_comb begin
        cnt_d   = '0;
        err_set = 1'b0;
        if (is_wait(state_d)) begin
            cnt_d = (state_d != state_q) ? '0 : sat_inc(cnt_q);
        end
        if (is_wait(state_q) && (cnt_q == CNT_ERR)) begin
            err_set = 1'b1;
        end
    end

    // Stage: state and outputs, decoded from the next state so they move together.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q       <= RUNNING;
            cnt_q         <= '0;
            halt_ack_q    <= 1'b0;
            run_ack_q     <= 1'b0;
            halt_req_q    <= 1'b0;
            run_req_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halt_ack_q <= (state_d == HALTED) && arc.core_halted;
            run_ack_q  <= (state_d == RUNNING) && !arc.core_halted;
            halt_req_q <= (state_d == HALTING);
            run_req_q  <= (state_d == RESUMING);
            if (err_set) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign arc.ext_arc_halt_ack = halt_ack_q;
    assign arc.ext_arc_run_ack  = run_ack_q;
    assign arc.core_halt_req    = halt_req_q;
    assign arc.core_run_req     = run_req_q;
    assign timeout_err          = timeout_err_q;
    assign fsm_state            = state_q;

    a_acks_exclusive: assert property (@(posedge clk) disable iff (!rst_a)
        !(halt_ack_q && run_ack_q));

    a_reqs_exclusive: assert property (@(posedge clk) disable iff (!rst_a)
        !(halt_req_q && run_req_q));

    a_halt_ack_needs_halted: assert property (@(posedge clk) disable iff (!rst_a)
        halt_ack_q |-> $past(arc.core_halted));

endmodule

// File: tb/tb_arc_halt_run_responder.sv
// Bench for arc_halt_run_responder: directed handshake scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the handshake rules.
module tb_arc_halt_run_responder;
    localparam int SYNC_STAGES = 2;
    localparam int ACK_TIMEOUT = 16;
    localparam int CNT_W       = 5;

    logic       clk     = 1'b0;
    logic       rst_a   = 1'b0;
    logic       err_clr = 1'b0;
    logic       timeout_err;
    logic [1:0] fsm_state;
    int         checks  = 0;
    int         errors  = 0;

    arc_halt_run_responder_if bus ();

    arc_halt_run_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_a       (rst_a),
        .arc         (bus.slave),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    // Behavioural reference: mode names follow the documented encoding.
    localparam int M_RUN = 0, M_HALTING = 1, M_HALTED = 2, M_RESUMING = 3;
    int   m_mode;
    int   m_age;
    bit   m_err;
    bit   m_hist[$];
    bit   e_halt_ack, e_run_ack, e_halt_req, e_run_req;
    int   e_state;

    task automatic model_reset();
        m_mode = M_RUN;
        m_age  = 0;
        m_err  = 1'b0;
        m_hist = {};
        for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
        e_halt_ack = 0; e_run_ack = 0; e_halt_req = 0; e_run_req = 0; e_state = 0;
    endtask

    task automatic model_step();
        bit seen_req;
        bit halted;
        int nx;
        bit waiting_now, waiting_next;
        seen_req = m_hist[0];
        halted   = bus.core_halted;
        nx       = m_mode;
        if (m_mode == M_RUN && seen_req) nx = M_HALTING;
        else if (m_mode == M_HALTING) nx = !seen_req ? M_RESUMING : (halted ? M_HALTED : M_HALTING);
        else if (m_mode == M_HALTED && !seen_req) nx = M_RESUMING;
        else if (m_mode == M_RESUMING && !halted) nx = seen_req ? M_HALTING : M_RUN;
        waiting_now  = (m_mode == M_HALTING) || (m_mode == M_RESUMING);
        waiting_next = (nx == M_HALTING) || (nx == M_RESUMING);
        if (waiting_now && m_age == ACK_TIMEOUT - 1) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (!waiting_next) m_age = 0;
        else if (nx != m_mode) m_age = 0;
        else m_age = m_age + 1;
        e_halt_ack = (nx == M_HALTED);
        e_run_ack  = (nx == M_RUN) && !halted;
        e_halt_req = (nx == M_HALTING);
        e_run_req  = (nx == M_RESUMING);
        e_state    = nx;
        m_mode     = nx;
        m_hist.push_back(bus.ext_arc_halt_req_a);
        void'(m_hist.pop_front());
    endtask

    // One clock: the model sees the same inputs the DUT samples; return on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_a) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        rst_a = 1'b0;
        bus.ext_arc_halt_req_a = 1'b0;
        bus.core_halted = 1'b0;
        err_clr = 1'b0;
        model_reset();
        tick();
        tick();
        outs = {bus.ext_arc_halt_ack, bus.ext_arc_run_ack, bus.core_halt_req,
                bus.core_run_req, timeout_err, fsm_state};
        checks++;
        if (outs !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", outs, 7'b0);
        end
        rst_a = 1'b1;
        tick();
        checks++;
        if (bus.ext_arc_run_ack !== 1'b1) begin
            errors++; $display("FAIL reset_release_run_ack: got %b expected 1", bus.ext_arc_run_ack);
        end
        checks++;
        if (bus.ext_arc_halt_ack !== 1'b0 || fsm_state !== 2'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_state: got halt_ack=%b state=%0d err=%b expected 0/0/0",
                     bus.ext_arc_halt_ack, fsm_state, timeout_err);
        end
    endtask

    task automatic test_halt_round_trip();
        int n;
        bus.ext_arc_halt_req_a = 1'b1;
        n = 0;
        while (bus.core_halt_req !== 1'b1 && n < SYNC_STAGES + 1) begin tick(); n++; end
        checks++;
        if (bus.core_halt_req !== 1'b1 || fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL halt_req_latency: got halt_req=%b state=%0d after %0d cycles expected 1/1 within %0d",
                     bus.core_halt_req, fsm_state, n, SYNC_STAGES + 1);
        end
        repeat (5) tick();
        checks++;
        if (bus.ext_arc_halt_ack !== 1'b0 || bus.ext_arc_run_ack !== 1'b0) begin
            errors++;
            $display("FAIL halting_acks: got halt_ack=%b run_ack=%b expected 0/0",
                     bus.ext_arc_halt_ack, bus.ext_arc_run_ack);
        end
        bus.core_halted = 1'b1;
        tick();
        checks++;
        if (bus.ext_arc_halt_ack !== 1'b1 || bus.ext_arc_run_ack !== 1'b0 ||
            fsm_state !== 2'd2 || bus.core_halt_req !== 1'b0) begin
            errors++;
            $display("FAIL halted_entry: got halt_ack=%b run_ack=%b state=%0d halt_req=%b expected 1/0/2/0",
                     bus.ext_arc_halt_ack, bus.ext_arc_run_ack, fsm_state, bus.core_halt_req);
        end
        bus.ext_arc_halt_req_a = 1'b0;
        n = 0;
        while (bus.core_run_req !== 1'b1 && n < SYNC_STAGES + 1) begin tick(); n++; end
        checks++;
        if (bus.core_run_req !== 1'b1 || bus.ext_arc_halt_ack !== 1'b0 || fsm_state !== 2'd3) begin
            errors++;
            $display("FAIL resume_start: got run_req=%b halt_ack=%b state=%0d expected 1/0/3",
                     bus.core_run_req, bus.ext_arc_halt_ack, fsm_state);
        end
        repeat (3) tick();
        bus.core_halted = 1'b0;
        tick();
        checks++;
        if (bus.ext_arc_run_ack !== 1'b1 || bus.ext_arc_halt_ack !== 1'b0 ||
            fsm_state !== 2'd0 || bus.core_run_req !== 1'b0) begin
            errors++;
            $display("FAIL resume_done: got run_ack=%b halt_ack=%b state=%0d run_req=%b expected 1/0/0/0",
                     bus.ext_arc_run_ack, bus.ext_arc_halt_ack, fsm_state, bus.core_run_req);
        end
    endtask

    task automatic test_abort();
        bit saw_halting = 0, saw_resuming = 0, saw_ack = 0;
        bus.ext_arc_halt_req_a = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 4) bus.ext_arc_halt_req_a = 1'b0;
            tick();
            if (fsm_state === 2'd1) saw_halting = 1;
            if (fsm_state === 2'd3) saw_resuming = 1;
            if (bus.ext_arc_halt_ack === 1'b1) saw_ack = 1;
        end
        checks++;
        if (saw_halting !== 1'b1 || saw_resuming !== 1'b1) begin
            errors++;
            $display("FAIL abort_path: got halting=%b resuming=%b expected 1/1", saw_halting, saw_resuming);
        end
        checks++;
        if (saw_ack !== 1'b0) begin
            errors++; $display("FAIL abort_no_halt_ack: got %b expected 0", saw_ack);
        end
        checks++;
        if (fsm_state !== 2'd0 || bus.ext_arc_run_ack !== 1'b1) begin
            errors++;
            $display("FAIL abort_return: got state=%0d run_ack=%b expected 0/1", fsm_state, bus.ext_arc_run_ack);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit err_early = 0;
        bus.ext_arc_halt_req_a = 1'b1;
        n = 0;
        while (fsm_state !== 2'd1 && n < SYNC_STAGES + 1) begin tick(); n++; end
        checks++;
        if (fsm_state !== 2'd1) begin
            errors++; $display("FAIL timeout_entry: got state=%0d expected 1", fsm_state);
        end
        for (int i = 1; i < ACK_TIMEOUT; i++) begin
            tick();
            if (timeout_err !== 1'b0) err_early = 1;
        end
        checks++;
        if (err_early !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got err before %0d cycles expected none", ACK_TIMEOUT);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL timeout_set: got err=%b state=%0d expected 1/1", timeout_err, fsm_state);
        end
        bus.core_halted = 1'b1;
        tick();
        checks++;
        if (bus.ext_arc_halt_ack !== 1'b1 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_late_halt: got halt_ack=%b err=%b expected 1/1", bus.ext_arc_halt_ack, timeout_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
        bus.ext_arc_halt_req_a = 1'b0;
        n = 0;
        while (fsm_state !== 2'd3 && n < SYNC_STAGES + 1) begin tick(); n++; end
        bus.core_halted = 1'b0;
        tick();
        checks++;
        if (fsm_state !== 2'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: got state=%0d err=%b expected 0/0", fsm_state, timeout_err);
        end
    endtask

    task automatic test_spontaneous_halt();
        bus.core_halted = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.ext_arc_run_ack !== 1'b0 || bus.ext_arc_halt_ack !== 1'b0 ||
            fsm_state !== 2'd0 || bus.core_halt_req !== 1'b0) begin
            errors++;
            $display("FAIL spont_halt: got run_ack=%b halt_ack=%b state=%0d halt_req=%b expected 0/0/0/0",
                     bus.ext_arc_run_ack, bus.ext_arc_halt_ack, fsm_state, bus.core_halt_req);
        end
        bus.core_halted = 1'b0;
        tick();
        checks++;
        if (bus.ext_arc_run_ack !== 1'b1) begin
            errors++; $display("FAIL spont_resume: got run_ack=%b expected 1", bus.ext_arc_run_ack);
        end
    endtask

    task automatic test_reset_mid_halted();
        int n;
        logic [6:0] outs;
        bus.ext_arc_halt_req_a = 1'b1;
        n = 0;
        while (bus.core_halt_req !== 1'b1 && n < SYNC_STAGES + 1) begin tick(); n++; end
        bus.core_halted = 1'b1;
        tick();
        checks++;
        if (fsm_state !== 2'd2) begin
            errors++; $display("FAIL midrst_reach_halted: got state=%0d expected 2", fsm_state);
        end
        rst_a = 1'b0;
        #1;
        model_reset();
        outs = {bus.ext_arc_halt_ack, bus.ext_arc_run_ack, bus.core_halt_req,
                bus.core_run_req, timeout_err, fsm_state};
        checks++;
        if (outs !== 7'b0) begin
            errors++; $display("FAIL midrst_outputs: got %b expected %b", outs, 7'b0);
        end
        tick();
        rst_a = 1'b1;
        n = 0;
        while (fsm_state !== 2'd1 && n < 3) begin tick(); n++; end
        checks++;
        if (fsm_state !== 2'd1 || bus.core_halt_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_rehalt: got state=%0d halt_req=%b after %0d cycles expected 1/1 within 3",
                     fsm_state, bus.core_halt_req, n);
        end
        tick();
        checks++;
        if (bus.ext_arc_halt_ack !== 1'b1) begin
            errors++; $display("FAIL midrst_halt_ack: got %b expected 1", bus.ext_arc_halt_ack);
        end
        bus.ext_arc_halt_req_a = 1'b0;
        n = 0;
        while (fsm_state !== 2'd3 && n < SYNC_STAGES + 1) begin tick(); n++; end
        bus.core_halted = 1'b0;
        tick();
        checks++;
        if (fsm_state !== 2'd0) begin
            errors++; $display("FAIL midrst_recover: got state=%0d expected 0", fsm_state);
        end
    endtask

    task automatic test_random();
        int req_hold = 3;
        int h_dly = -1;
        int r_dly = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_hold--;
            if (req_hold <= 0) begin
                bus.ext_arc_halt_req_a = ~bus.ext_arc_halt_req_a;
                req_hold = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 30));
            end
            if (bus.core_halt_req && !bus.core_halted) begin
                if (h_dly < 0) h_dly = $urandom_range(0, 20);
                else if (h_dly == 0) begin bus.core_halted = 1'b1; h_dly = -1; end
                else h_dly--;
            end else h_dly = -1;
            if (bus.core_run_req && bus.core_halted) begin
                if (r_dly < 0) r_dly = $urandom_range(0, 8);
                else if (r_dly == 0) begin bus.core_halted = 1'b0; r_dly = -1; end
                else r_dly--;
            end else r_dly = -1;
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (fsm_state !== 2'(e_state)) begin
                errors++; $display("FAIL rand_state cyc %0d: got %0d expected %0d", cyc, fsm_state, e_state);
            end
            checks++;
            if (bus.ext_arc_halt_ack !== e_halt_ack || bus.ext_arc_run_ack !== e_run_ack) begin
                errors++;
                $display("FAIL rand_acks cyc %0d: got halt_ack=%b run_ack=%b expected %b/%b",
                         cyc, bus.ext_arc_halt_ack, bus.ext_arc_run_ack, e_halt_ack, e_run_ack);
            end
            checks++;
            if (bus.core_halt_req !== e_halt_req || bus.core_run_req !== e_run_req) begin
                errors++;
                $display("FAIL rand_reqs cyc %0d: got halt_req=%b run_req=%b expected %b/%b",
                         cyc, bus.core_halt_req, bus.core_run_req, e_halt_req, e_run_req);
            end
            checks++;
            if (timeout_err !== m_err) begin
                errors++; $display("FAIL rand_timeout cyc %0d: got %b expected %b", cyc, timeout_err, m_err);
            end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_halt_round_trip();
        test_abort();
        test_timeout();
        test_spontaneous_halt();
        test_reset_mid_halted();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arc_halt_run_responder.md
Name: arc_halt_run_responder

Overview:
- Core-side responder for the external ARC halt/run handshake. The testbench or host drives `ext_arc_halt_req_a`; this block answers with `ext_arc_halt_ack` and `ext_arc_run_ack`.
- It synchronizes the asynchronous halt request and drives the core's halt/run request lines. It tracks the core's halted status and flags handshake timeouts.
- One instance sits beside each L2 ARC (nl2arc0/1) and each slice L1 ARC (sl0..sl15).

Parameters:
- SYNC_STAGES, 2, synchronizer flops on `ext_arc_halt_req_a`; legal range 2..4.
- ACK_TIMEOUT, 1024, cycles allowed in HALTING or RESUMING before `timeout_err` sets; must be ≥ 2.
- CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- `clk` in 1: single block clock.
- `rst_a` in 1: asynchronous, active-low reset.
- `ext_arc_halt_req_a` in 1: asynchronous level halt request (4-phase handshake).
- `ext_arc_halt_ack` out 1: halt acknowledge; high while the core is halted on request.
- `ext_arc_run_ack` out 1: run status; high while the core is running and no halt is pending.
- `core_halt_req` out 1: level halt request to the core.
- `core_run_req` out 1: level run request to the core.
- `core_halted` in 1: core halted status, synchronous to `clk`.
- `err_clr` in 1: one-cycle pulse that clears `timeout_err`.
- `timeout_err` out 1: sticky handshake-timeout flag.
- `fsm_state` out 2: current state encoding, for debug.

Behaviour:
- Reset (`rst_a`=0): all outputs 0, synchronizer cleared, counter 0, state RUNNING (encoding 0).
- Synchronizer: `req_s` is `ext_arc_halt_req_a` after SYNC_STAGES flops. No other logic uses the raw input.
- All outputs are registered and are decoded from the next state, so they change on the same edge as the state.
- States: RUNNING=0, HALTING=1, HALTED=2, RESUMING=3.
- RUNNING:
  - `ext_arc_run_ack` = !`core_halted` (registered). Both requests low.
  - `req_s`=1 → HALTING.
  - If the core halts on its own (breakpoint), `run_ack` drops but the state stays RUNNING and `halt_ack` stays 0.
- HALTING:
  - `core_halt_req`=1, `run_ack`=0.
  - `core_halted`=1 and `req_s`=1 → HALTED.
  - `req_s`=0 before the core halts (abort) → RESUMING.
  - If `core_halted` and `req_s`=0 are seen in the same cycle, the abort wins → RESUMING.
- HALTED:
  - `ext_arc_halt_ack`=1, `core_halt_req`=0.
  - `req_s`=0 → RESUMING; `halt_ack` drops on the same edge.
- RESUMING:
  - `core_run_req`=1, `halt_ack`=0.
  - `core_halted`=0 → RUNNING; `run_ack`=1 on the same edge.
  - `req_s`=1 while still resuming → stays in RESUMING until the core runs, then goes to HALTING.
  - The core is never left mid-transition.
- Latency:
  - Request edge at the input → `core_halt_req` high within SYNC_STAGES+1 cycles.
  - `core_halted` rise in HALTING → `halt_ack` high on the next edge.
  - Request fall → `halt_ack` low within SYNC_STAGES+1 cycles.
- Timeout counter:
  - Clears on entry to HALTING or RESUMING and increments each cycle in those states. It saturates at ACK_TIMEOUT.
  - When the count reaches ACK_TIMEOUT-1 in a given state, `timeout_err` sets on the next edge. The FSM keeps waiting; no forced transition.
  - `timeout_err` is sticky until `err_clr`. If a set and `err_clr` occur in the same cycle, set wins.
  - Counter is 0 in RUNNING and HALTED.
- Handshake invariants (assertions):
  - `halt_ack` and `run_ack` are never both 1.
  - `core_halt_req` and `core_run_req` are never both 1.
  - `halt_ack` implies `core_halted`=1, sampled the cycle before.
- Reset mid-operation: everything returns to reset values immediately (asynchronous), including request lines driven to the core. After reset release the FSM resumes from RUNNING, and `run_ack` reflects `core_halted`.
- Glitch on `ext_arc_halt_req_a` shorter than one `clk` period: it may or may not be captured. If captured, a full HALTING→RESUMING sequence follows; no illegal state is reachable.

Test Plan:
- Reset release with `core_halted`=0 → cycle 1: `run_ack`=1, `halt_ack`=0, `fsm_state`=0, `timeout_err`=0.
- Halt round trip (SYNC_STAGES=2):
  - Raise request at cycle 10 → `core_halt_req`=1 by cycle 13.
  - Core model halts after 5 cycles → `halt_ack`=1 on the next edge, `run_ack`=0.
  - Drop request → `core_run_req`=1.
  - Core runs after 3 cycles → `run_ack`=1, `halt_ack`=0.
- Abort: pulse request for 4 cycles; core model never halts → HALTING then RESUMING. `halt_ack` never asserts. Returns to RUNNING with `run_ack`=1.
- Timeout: ACK_TIMEOUT=16, core ignores the halt → `timeout_err`=1 exactly 16 cycles after HALTING entry, state stays HALTING.
  - Core then halts → `halt_ack`=1.
  - `err_clr` pulse → `timeout_err`=0.
- Spontaneous halt: `core_halted`=1 in RUNNING with no request → `run_ack`=0, `halt_ack`=0, `fsm_state`=0.
- Assert `rst_a`=0 while in HALTED → all outputs 0 immediately. After release, request still high → re-enters HALTING within 3 cycles.
